// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types and default widths for the inter-stage pipeline buffer.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 16;
    localparam int DEF_CNT_W  = 16;

    localparam logic [DEF_CTRL_W-1:0] CTRL_ZERO = '0;

endpackage

// File: rtl/pipe_stage_buffer_dff_en.sv
// Register slice with load enable and synchronous clear; one per stored field.
module pipe_dff_en #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline register with stall, flush and a back-pressure counter.
// Define PIPE_SKID_EN for the two-entry build with a purely registered in_ready.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bp_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_state_t       state;
    pipe_state_t       state_next;
    logic              push;
    logic              pop;
    logic              bp_inc;
    logic              head_load;
    logic              head_clr;
    logic [DATA_W-1:0] head_d_data;
    logic [CTRL_W-1:0] head_d_ctrl;

    assign out_valid = (state != PS_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~stall;
    assign bp_inc    = out_valid & ~out_ready & ~stall & ~flush;

`ifdef PIPE_SKID_EN
    logic              ready_q;
    logic              skid_load;
    logic              skid_clr;
    logic              head_from_skid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // in_ready only sees stall combinationally; out_ready reaches it through a flop.
    assign in_ready    = ready_q & ~stall;
    assign head_d_data = head_from_skid ? skid_data : in_data;
    assign head_d_ctrl = head_from_skid ? skid_ctrl : in_ctrl;
`else
    assign in_ready    = ~stall & (~out_valid | out_ready);
    assign head_d_data = in_data;
    assign head_d_ctrl = in_ctrl;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        head_load  = 1'b0;
        head_clr   = 1'b0;
`ifdef PIPE_SKID_EN
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        head_from_skid = 1'b0;
`endif
        if (flush) begin
            state_next = PS_EMPTY;
            head_clr   = 1'b1;
`ifdef PIPE_SKID_EN
            skid_clr   = 1'b1;
`endif
        end else if (!stall) begin
            case (state)
                PS_EMPTY: begin
                    if (push) begin
                        state_next = PS_ONE;
                        head_load  = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
`ifdef PIPE_SKID_EN
                    end else if (push) begin
                        state_next = PS_TWO;
                        skid_load  = 1'b1;
`endif
                    end else if (pop) begin
                        state_next = PS_EMPTY;
                        head_clr   = 1'b1;
                    end
                end
`ifdef PIPE_SKID_EN
                PS_TWO: begin
                    if (pop) begin
                        state_next     = PS_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
`endif
                default: state_next = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= PS_EMPTY;
            bp_count <= '0;
        end else begin
            state <= state_next;
            if (bp_inc && (bp_count != CNT_MAX)) begin
                bp_count <= bp_count + CNT_ONE;
            end
        end
    end

    // Payload survives a flush; only the control word is forced to a bubble.
    pipe_dff_en #(.W(DATA_W)) u_head_data (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (head_load),
        .clr   (1'b0),
        .d     (head_d_data),
        .q     (out_data)
    );

    pipe_dff_en #(.W(CTRL_W)) u_head_ctrl (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (head_load),
        .clr   (head_clr),
        .d     (head_d_ctrl),
        .q     (out_ctrl)
    );

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_next != PS_TWO);
        end
    end

    pipe_dff_en #(.W(DATA_W)) u_skid_data (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (skid_load),
        .clr   (1'b0),
        .d     (in_data),
        .q     (skid_data)
    );

    pipe_dff_en #(.W(CTRL_W)) u_skid_ctrl (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (skid_load),
        .clr   (skid_clr),
        .d     (in_ctrl),
        .q     (skid_ctrl)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer; expectations follow PIPE_SKID_EN when defined.
module tb_pipe_stage_buffer;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_b;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  bp_count;

    int vectors;
    int miscompares;

    pipe_stage_buffer #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .bp_count  (bp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CTRL_W-1:0] ctl_of(input logic [DATA_W-1:0] d);
        return 16'h5A00 ^ d[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = ctl_of(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_b       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_ctrl     = '0;
        stall       = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        check("rst_bp_count", 32'(bp_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_b = 1'b1;

        // Stream 1..8 at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i));
            @(negedge clk);
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", out_data, 32'(i));
            check("stream_ctrl", 32'(out_ctrl), 32'(ctl_of(32'(i))));
        end
        drive(1'b0, 32'h0);
        @(negedge clk);
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_ctrl", 32'(out_ctrl), 32'd0);
        check("drain_data_held", out_data, 32'h8);
        check("stream_bp", 32'(bp_count), 32'd0);

        // Back-pressure: 0xA then 0xB with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 32'hA);
        @(negedge clk);
        check("bp_head_a", out_data, 32'hA);
        check("bp_cnt0", 32'(bp_count), 32'd0);
        drive(1'b1, 32'hB);
        #1;
`ifdef PIPE_SKID_EN
        check("bp_ready_b", 32'(in_ready), 32'd1);
`else
        check("bp_ready_b", 32'(in_ready), 32'd0);
`endif
        @(negedge clk);
        check("bp_cnt1", 32'(bp_count), 32'd1);
        check("bp_hold_a", out_data, 32'hA);
`ifdef PIPE_SKID_EN
        drive(1'b0, 32'h0);
`endif
        check("bp_ready_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp_cnt2", 32'(bp_count), 32'd2);
        check("bp_still_a", out_data, 32'hA);
        out_ready = 1'b1;
        #1;
`ifdef PIPE_SKID_EN
        check("bp_ready_two", 32'(in_ready), 32'd0);
`else
        check("bp_ready_pass", 32'(in_ready), 32'd1);
`endif
        @(negedge clk);
        drive(1'b0, 32'h0);
        check("bp_head_b", out_data, 32'hB);
        check("bp_ctrl_b", 32'(out_ctrl), 32'(ctl_of(32'hB)));
        check("bp_cnt_kept", 32'(bp_count), 32'd2);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Stall with head 0xC
        out_ready = 1'b0;
        drive(1'b1, 32'hC);
        @(negedge clk);
        check("stall_head_c", out_data, 32'hC);
        stall     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hEE);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_data", out_data, 32'hC);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_bp", 32'(bp_count), 32'd2);
        end
        stall     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0);
        @(negedge clk);
        check("resume_bp", 32'(bp_count), 32'd3);
        check("resume_data", out_data, 32'hC);

        // Flush while holding 0xC with 0xD arriving
        flush = 1'b1;
        drive(1'b1, 32'hD);
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ctrl", 32'(out_ctrl), 32'd0);
        check("flush_data_held", out_data, 32'hC);
        check("flush_bp", 32'(bp_count), 32'd3);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0);
        @(negedge clk);
        check("flush_no_d_valid", 32'(out_valid), 32'd0);
        check("flush_no_d_data", out_data, 32'hC);

        // Saturation of the 4-bit counter
        out_ready = 1'b0;
        drive(1'b1, 32'hF);
        @(negedge clk);
        drive(1'b0, 32'h0);
        check("sat_start", 32'(bp_count), 32'd3);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i == 10) check("sat_mid", 32'(bp_count), 32'd14);
        end
        check("sat_final", 32'(bp_count), 32'd15);
        check("sat_data", out_data, 32'hF);

        // Asynchronous reset mid-transfer (skid build reaches TWO here)
        drive(1'b1, 32'h10);
        @(negedge clk);
`ifdef PIPE_SKID_EN
        drive(1'b0, 32'h0);
        check("pre_rst_ready", 32'(in_ready), 32'd0);
`endif
        #2;
        rst_b = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_ctrl", 32'(out_ctrl), 32'd0);
        check("mid_rst_bp", 32'(bp_count), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_b     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h11);
        @(negedge clk);
        drive(1'b0, 32'h0);
        check("post_rst_data", out_data, 32'h11);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("post_rst_drain", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised inter-stage pipeline register replacing the per-field flip-flop buffers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries one packed payload plus a control word under a valid/ready handshake, with stall (hold) and flush (bubble insertion) support. An optional second skid entry decouples upstream ready from downstream ready. A saturating counter reports back-pressure cycles for performance debug.

## Interface

- DATA_W, 32: payload width (operands, PC, immediates); preserved on flush.
- CTRL_W, 16: control-word width (write enables, ALU op, halt, etc.); forced to zero on flush/bubble.
- CNT_W, 16: width of the back-pressure counter.

- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage presents an instruction.
- in_ready  out  1  buffer accepts this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control word.
- stall  in  1  hold current contents; no accept, no release.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control; zero whenever out_valid=0.
- bp_count  out  CNT_W  saturating count of cycles with out_valid=1, out_ready=0, stall=0.

## Operation

- Accept = in_valid & in_ready; release = out_valid & out_ready & !stall.
- Priority per cycle: flush > stall > normal handshake.
- flush: all entries invalidated, out_ctrl=0, out_data held; incoming accept in the same cycle discarded; bp_count unchanged.
- stall: in_ready=0, entries and outputs frozen, out_ready ignored.
- Without skid: states EMPTY, FULL. in_ready = !stall & (!out_valid | out_ready) (combinational pass-through of out_ready). Simultaneous accept+release: new entry replaces head, stays FULL.
- With skid: states EMPTY, ONE, TWO. in_ready = !stall & (state != TWO), registered. EMPTY–accept→ONE; ONE–accept & !release→TWO (new entry to skid slot); ONE–release & !accept→EMPTY; ONE–both→ONE (head replaced); TWO–release→ONE (skid moves to head); no accept in TWO.
- Ordering strictly FIFO; no entry duplicated or dropped except by flush.
- bp_count increments by 1, saturates at 2^CNT_W−1; cleared only by reset.

## Timing

- Reset (async assert, sync-deasserted externally): state EMPTY, out_valid=0, out_data=0, out_ctrl=0, bp_count=0, in_ready=1 (skid build: 1 from the first cycle after reset).
- Latency: accepted entry appears on out_* the next cycle (1 cycle) in both builds.
- Throughput: 1 entry/cycle with out_ready held high.
- flush effect visible the following cycle: out_valid=0.
- Reset mid-transfer drops all entries; no partial output.

## Configuration

- PIPE_SKID_EN defined: two-entry skid build, in_ready purely registered, full throughput with no combinational in_ready←out_ready path.
- Undefined: single-entry build, in_ready combinationally depends on out_ready and stall; area one register set.

## Structure

- Package pipe_pkg: state enum (PS_EMPTY, PS_ONE, PS_TWO), default width constants, zero control-word constant.
- One sub-module pipe_dff_en: parametrised width, async active-low reset, load enable and synchronous clear; instantiated per entry for data and control.
- Stage-specific payload packing lives in the instantiating stage, not here.

## Test plan

- Reset then stream 8 entries 0x1..0x8 with out_ready=1 → out_data 0x1..0x8 on consecutive cycles, one cycle after each accept; bp_count=0.
- Send 0xA, 0xB with out_ready=0 → skid build: in_ready drops after 2nd accept, state TWO; no-skid: in_ready=0 after 1st; bp_count increments each held cycle; release yields 0xA then 0xB.
- Hold stall=1 for 3 cycles with FULL head 0xC and out_ready=1 → out_data stays 0xC, in_ready=0, bp_count unchanged; resumes on stall=0.
- flush asserted with in_valid=1, in_data=0xD while holding 0xC → next cycle out_valid=0, out_ctrl=0; 0xD never appears.
- Hold out_ready=0 for 2^CNT_W+5 cycles (CNT_W=4) → bp_count saturates at 15.
- Assert rst_b=0 mid-stream in state TWO → outputs immediately zero, out_valid=0, bp_count=0.
